// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared calculator constants and multiply FSM state type
package calc_pkg;

    localparam int CALC_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mult_state_t;

endpackage

// File: rtl/pp_row.sv
// rtl/pp_row.sv - one row of 1-bit AND multiply cells forming a partial product
module pp_row #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] mcand_i,
    input  logic             bit_i,
    output logic [WIDTH-1:0] pp_o
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        assign pp_o[i] = mcand_i[i] & bit_i;
    end

endmodule

// File: rtl/mult_seq_ctrl.sv
// rtl/mult_seq_ctrl.sv - shift-add multiply controller reusing one partial-product row over WIDTH cycles
module mult_seq_ctrl
    import calc_pkg::*;
#(
    parameter int WIDTH = CALC_WIDTH
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [2*WIDTH-1:0] product_o
);

    localparam int CW = $clog2(WIDTH) + 1;

    mult_state_t        state_q, state_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [2*WIDTH-1:0] product_q, product_d;

    logic [WIDTH-1:0]   pp;
    logic [WIDTH:0]     sum;

    pp_row #(.WIDTH(WIDTH)) u_pp_row (
        .mcand_i (mcand_q),
        .bit_i   (mplier_q[0]),
        .pp_o    (pp)
    );

    assign sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, pp};

    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        done_d    = 1'b0;
        product_d = product_q;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    mcand_d  = a_i;
                    mplier_d = b_i;
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                // Carry out of the upper-half add enters the MSB as the accumulator shifts right.
                acc_d    = {sum, acc_q[WIDTH-1:1]};
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                product_d = acc_q;
                done_d    = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Busy covers the cycle carrying the done pulse as well, so it falls together with done.
        busy_d = (state_d != IDLE) || (state_q == DONE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            product_q <= product_d;
        end
    end

    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign product_o = product_q;

endmodule
